// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, relative branch, jump, and an optional
// return-address stack compiled in with `define PC_SEQ_RAS_EN.
module pc_sequencer #(
    parameter int              PC_W      = 8,
    parameter int              OFF_W     = 8,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             cond,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic [1:0]       flags,
    output logic             ras_empty,
    output logic             ras_full
);

    typedef enum logic [2:0] {
        OP_INC   = 3'b000,
        OP_BRREL = 3'b001,
        OP_JMP   = 3'b010,
        OP_CALL  = 3'b011,
        OP_RET   = 3'b100
    } op_e;

    logic [PC_W-1:0] pc_inc;
    logic            inc_wrap;
    logic [PC_W+1:0] off_ext;
    logic [PC_W+1:0] br_sum;
    logic [PC_W-1:0] pc_nxt;
    logic            wrap_nxt;
    logic            wrap_q;
    logic            err_q;

    // Two guard bits above the PC: bit PC_W catches carry, bit PC_W+1 catches borrow.
    assign {inc_wrap, pc_inc} = {1'b0, pc} + (PC_W+1)'(1);
    assign off_ext = {{(PC_W+2-OFF_W){offset[OFF_W-1]}}, offset};
    assign br_sum  = {2'b00, pc} + off_ext;
    assign flags   = {err_q, wrap_q};

`ifdef PC_SEQ_RAS_EN
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [CNT_W-1:0] ras_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic             push;
    logic             pop;
    logic             err_nxt;

    assign push_idx = IDX_W'(ras_cnt);
    assign top_idx  = IDX_W'(ras_cnt - CNT_W'(1));
`endif

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        pc_nxt   = pc_inc;
        wrap_nxt = inc_wrap;
`ifdef PC_SEQ_RAS_EN
        push     = 1'b0;
        pop      = 1'b0;
        err_nxt  = 1'b0;
`endif
        case (op)
            OP_INC: ;
            OP_BRREL: begin
                if (cond) begin
                    pc_nxt   = br_sum[PC_W-1:0];
                    wrap_nxt = br_sum[PC_W+1] | br_sum[PC_W];
                end
            end
            OP_JMP: begin
                pc_nxt   = target;
                wrap_nxt = 1'b0;
            end
            OP_CALL: begin
                pc_nxt   = target;
                wrap_nxt = 1'b0;
`ifdef PC_SEQ_RAS_EN
                if (ras_full) err_nxt = 1'b1;
                else          push    = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PC_SEQ_RAS_EN
                // An empty-stack return falls through to pc+1 but never reports wrap.
                wrap_nxt = 1'b0;
                if (ras_empty) begin
                    err_nxt = 1'b1;
                end else begin
                    pop    = 1'b1;
                    pc_nxt = ras_mem[top_idx];
                end
`endif
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_VEC;
            wrap_q <= 1'b0;
        end else if (en) begin
            pc     <= pc_nxt;
            wrap_q <= wrap_nxt;
        end else begin
            wrap_q <= 1'b0;
        end
    end

`ifdef PC_SEQ_RAS_EN
    always_comb begin
        cnt_nxt = ras_cnt;
        if (push)     cnt_nxt = ras_cnt + CNT_W'(1);
        else if (pop) cnt_nxt = ras_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_cnt   <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            err_q     <= 1'b0;
        end else if (en) begin
            ras_cnt   <= cnt_nxt;
            ras_empty <= (cnt_nxt == '0);
            ras_full  <= (cnt_nxt == CNT_W'(RAS_DEPTH));
            err_q     <= err_nxt;
        end else begin
            err_q     <= 1'b0;
        end
    end

    // NOTE: stack storage is deliberately not reset; the count alone defines valid entries.
    always_ff @(posedge clk) begin
        if (!reset && en && push) ras_mem[push_idx] <= pc_inc;
    end
`else
    assign err_q     = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
`endif

endmodule
